// File: rtl/word_relay_fifo.sv
// Word relay between a serial collector and a serial emitter: edge-detected capture,
// a DEPTH-word FIFO with sticky overflow, and a three-state transmit handshake FSM.
module word_relay_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     fast_clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     tx_start,
    input  logic                     tx_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } tx_state_t;

    tx_state_t        state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             in_valid_q;
    logic             push;
    logic             pop;
    logic             accept;

    assign push   = in_valid & ~in_valid_q;
    assign pop    = (state == IDLE) & ~empty;
    // A push on a full FIFO still fits when the head leaves on the same edge.
    assign accept = push & (~full | pop);

    // Reset is synchronous, so the flags are forced while it is held rather than
    // waiting for the first reset edge to clear count.
    assign empty  = ~reset | (count == '0);
    assign full   = reset & (count == CW'(DEPTH));

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of push/pop/accept, whatever the block order.
    always_ff @(posedge fast_clk) begin
        if (!reset) begin
            in_valid_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !accept) overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count already mark
    // every entry invalid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge fast_clk) begin
        if (accept) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge fast_clk) begin
        if (!reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_done) begin
                        tx_start <= 1'b0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!tx_done) state <= IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_relay_fifo.sv
// Directed bench for word_relay_fifo: reset, single word, fill/overflow/drain,
// level in_valid, push-on-full with pop, and reset in the middle of a send.
module tb_word_relay_fifo;

    localparam int WIDTH = 25;
    localparam int DEPTH = 4;

    logic             fast_clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_start;
    logic             tx_done;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;

    int tests_run;
    int tests_failed;

    word_relay_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .fast_clk (fast_clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    // Expect word w on the emitter port, then complete one tx_done handshake.
    task automatic handshake_expect(input string tag, input logic [WIDTH-1:0] w);
        check({tag, "_start"}, 32'(tx_start), 32'd1);
        check({tag, "_data"}, 32'(tx_data), 32'(w));
        tx_done = 1'b1;
        tick();
        check({tag, "_start_clr"}, 32'(tx_start), 32'd0);
        tx_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) tick();
        reset = 1'b1;
        tick();
    endtask

    int max_count;
    int starts;
    logic prev_start;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        tx_done  = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_empty_during", 32'(empty), 32'd1);
        check("rst_full_during", 32'(full), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick();

        // Single word with two-edge push-to-start latency
        in_data  = 25'd3461;
        in_valid = 1'b1;
        tick();
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_no_start_yet", 32'(tx_start), 32'd0);
        tick();
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'd3461);
        check("single_count_popped", 32'(count), 32'd0);
        in_valid = 1'b0;
        tx_done  = 1'b1;
        tick();
        check("single_start_clr", 32'(tx_start), 32'd0);
        tx_done = 1'b0;
        tick();
        tick();
        check("single_idle_empty", 32'(empty), 32'd1);
        check("single_idle_no_start", 32'(tx_start), 32'd0);
        check("single_data_retained", 32'(tx_data), 32'd3461);

        // Fill and overflow with tx_done held low
        for (int k = 1; k <= 6; k++) push_word(WIDTH'(k));
        check("fill_head_data", 32'(tx_data), 32'd1);
        check("fill_start", 32'(tx_start), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        check("fill_full", 32'(full), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd1);
        for (int k = 1; k <= 5; k++) handshake_expect($sformatf("drain%0d", k), WIDTH'(k));
        check("drain_count", 32'(count), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_no_start", 32'(tx_start), 32'd0);
        check("drain_overflow_sticky", 32'(overflow), 32'd1);

        // Level in_valid for 10 cycles yields exactly one word
        do_reset(1);
        check("level_overflow_cleared", 32'(overflow), 32'd0);
        in_data   = 25'h1FF_FFFF;
        in_valid  = 1'b1;
        max_count = 0;
        starts    = 0;
        prev_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int'(count) > max_count) max_count = int'(count);
            if (tx_start && !prev_start) starts++;
            prev_start = tx_start;
        end
        check("level_data", 32'(tx_data), 32'h1FF_FFFF);
        check("level_max_count", 32'(max_count), 32'd1);
        check("level_count_end", 32'(count), 32'd0);
        in_valid = 1'b0;
        tx_done  = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_start && !prev_start) starts++;
            prev_start = tx_start;
        end
        check("level_one_send", 32'(starts), 32'd1);
        check("level_empty", 32'(empty), 32'd1);

        // Push on a full FIFO on the same edge as a pop
        do_reset(2);
        for (int k = 10; k <= 14; k++) push_word(WIDTH'(k));
        check("pf_full", 32'(full), 32'd1);
        check("pf_head", 32'(tx_data), 32'd10);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        in_data  = 25'd15;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pf_count_kept", 32'(count), 32'd4);
        check("pf_overflow_clear", 32'(overflow), 32'd0);
        check("pf_full_kept", 32'(full), 32'd1);
        tick();
        for (int k = 11; k <= 15; k++) handshake_expect($sformatf("pf_order%0d", k), WIDTH'(k));
        check("pf_end_empty", 32'(empty), 32'd1);

        // Reset while a word is in flight and another is buffered
        push_word(25'd77);
        push_word(25'd78);
        check("ms_start_before", 32'(tx_start), 32'd1);
        check("ms_count_before", 32'(count), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("ms_start_cleared", 32'(tx_start), 32'd0);
        check("ms_count_cleared", 32'(count), 32'd0);
        check("ms_empty", 32'(empty), 32'd1);
        in_data  = 25'd69420;
        in_valid = 1'b1;
        tick();
        check("ms_no_start_capture", 32'(tx_start), 32'd0);
        tick();
        check("ms_restart_start", 32'(tx_start), 32'd1);
        check("ms_restart_data", 32'(tx_data), 32'd69420);
        in_valid = 1'b0;
        tick();
        check("ms_no_stale_word", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
